// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: pipelined carry-lookahead adder/subtractor with a
// valid/ready handshake.
//
// WIDTH is cut into STAGES equal slices. Pipeline stage k adds slice k
// with a CLA built from BLOCK-bit generate/propagate groups. The carry out
// of each slice is registered and feeds the next stage. The operands and
// the sum bits produced so far travel down the pipe with the beat. One
// global enable advances every stage, or holds them all when the output is
// stalled.
//
// Ports:
//   clk, rst_n            clock; asynchronous active-low reset
//   in_valid / in_ready   operand beat handshake
//   a, b, cin, op_sub     operands; op_sub=1 computes a - b - cin
//   out_valid / out_ready result beat handshake
//   sum, cout             result; for subtract, cout=1 means no borrow
//   overflow, zero        two's complement overflow; sum == 0
module cla_pipe_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int BLOCK  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);
    localparam int SW = WIDTH / STAGES;  // slice width
    localparam int NG = SW / BLOCK;      // lookahead groups per slice
    localparam int L  = STAGES - 1;      // index of the output stage

    // One slice: group generate/propagate resolve the carry into every
    // group at once; bits inside a group use their local carry chain.
    function automatic logic [SW:0] cla_slice(input logic [SW-1:0] x,
                                              input logic [SW-1:0] y,
                                              input logic          ci);
        logic [SW-1:0] g;
        logic [SW-1:0] p;
        logic [SW-1:0] s;
        logic [NG:0]   gc;
        logic          gg;
        logic          gp;
        logic          c;
        g     = x & y;
        p     = x ^ y;
        s     = '0;
        gc    = '0;
        gc[0] = ci;
        for (int j = 0; j < NG; j++) begin
            gg = 1'b0;
            gp = 1'b1;
            for (int i = 0; i < BLOCK; i++) begin
                gg = g[j*BLOCK+i] | (p[j*BLOCK+i] & gg);
                gp = gp & p[j*BLOCK+i];
            end
            gc[j+1] = gg | (gp & gc[j]);
            c = gc[j];
            for (int i = 0; i < BLOCK; i++) begin
                s[j*BLOCK+i] = p[j*BLOCK+i] ^ c;
                c            = g[j*BLOCK+i] | (p[j*BLOCK+i] & c);
            end
        end
        return {gc[NG], s};
    endfunction

    logic [WIDTH-1:0] b_eff;
    logic             c0;
    logic             en;

    // Subtract as a + ~b + ~cin, so cout=1 means no borrow.
    assign b_eff = op_sub ? ~b : b;
    assign c0    = op_sub ? ~cin : cin;

    // Stage registers (index = stage)
    logic             vld_p [STAGES];
    logic [WIDTH-1:0] a_p   [STAGES];
    logic [WIDTH-1:0] b_p   [STAGES];
    logic [WIDTH-1:0] s_p   [STAGES];
    logic             c_p   [STAGES];
    logic             ovf_p;
    logic             zero_p;

    // What each stage sees at its input, and what it will load
    logic             vld_src [STAGES];
    logic [WIDTH-1:0] a_src   [STAGES];
    logic [WIDTH-1:0] b_src   [STAGES];
    logic [WIDTH-1:0] s_src   [STAGES];
    logic             c_src   [STAGES];
    logic [WIDTH-1:0] s_nxt   [STAGES];
    logic             c_nxt   [STAGES];
    logic             ovf_nxt;
    logic             zero_nxt;

    assign vld_src[0] = in_valid;
    assign a_src[0]   = a;
    assign b_src[0]   = b_eff;
    assign s_src[0]   = '0;
    assign c_src[0]   = c0;

    for (genvar k = 1; k < STAGES; k++) begin : g_link
        assign vld_src[k] = vld_p[k-1];
        assign a_src[k]   = a_p[k-1];
        assign b_src[k]   = b_p[k-1];
        assign s_src[k]   = s_p[k-1];
        assign c_src[k]   = c_p[k-1];
    end

    // Bits above the current slice are still zero, so OR merges it in.
    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        logic [SW:0] res;
        assign res      = cla_slice(a_src[k][k*SW +: SW], b_src[k][k*SW +: SW], c_src[k]);
        assign s_nxt[k] = s_src[k] | (WIDTH'(res[SW-1:0]) << (k*SW));
        assign c_nxt[k] = res[SW];
    end

    assign ovf_nxt  = (a_src[L][WIDTH-1] == b_src[L][WIDTH-1]) &&
                      (s_nxt[L][WIDTH-1] != a_src[L][WIDTH-1]);
    assign zero_nxt = ~|s_nxt[L];

    assign en = !vld_p[L] || out_ready;

    // Stage boundary: every slot advances together; data only on valid
    // beats so the outputs and flags keep their last values across bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_p[k] <= 1'b0;
                a_p[k]   <= '0;
                b_p[k]   <= '0;
                s_p[k]   <= '0;
                c_p[k]   <= 1'b0;
            end
            ovf_p  <= 1'b0;
            zero_p <= 1'b1;
        end else if (en) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_p[k] <= vld_src[k];
                if (vld_src[k]) begin
                    a_p[k] <= a_src[k];
                    b_p[k] <= b_src[k];
                    s_p[k] <= s_nxt[k];
                    c_p[k] <= c_nxt[k];
                end
            end
            if (vld_src[L]) begin
                ovf_p  <= ovf_nxt;
                zero_p <= zero_nxt;
            end
        end
    end

    assign in_ready  = en;
    assign out_valid = vld_p[L];
    assign sum       = s_p[L];
    assign cout      = c_p[L];
    assign overflow  = ovf_p;
    assign zero      = zero_p;
endmodule
